// File: rtl/snake_engine.sv
// snake_engine: snake head / heading / apple game logic on an 8x8 playfield.
// Optional feature macro: WRAP_AROUND_EN (edges wrap modulo 8; DEAD unreachable).
module snake_engine #(
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned TICK_W      = 25
) (
  input  logic       clock,
  input  logic       restart_n,
  input  logic       start,
  input  logic       dir_up,
  input  logic       dir_down,
  input  logic       dir_left,
  input  logic       dir_right,
  output logic [5:0] position,
  output logic [5:0] apple,
  output logic [5:0] score,
  output logic       step,
  output logic       ate,
  output logic       game_over
);

  localparam int unsigned CELL_W = 6;
  localparam logic [CELL_W-1:0] INIT_POS   = CELL_W'(27);
  localparam logic [CELL_W-1:0] INIT_APPLE = CELL_W'(45);
  localparam logic [CELL_W-1:0] SCORE_MAX  = CELL_W'(63);
  localparam logic [CELL_W-1:0] LFSR_SEED  = 6'b100001;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EAT, S_DEAD} state_t;
  // Opposite headings differ only in bit 0.
  typedef enum logic [1:0] {H_UP = 2'b00, H_DOWN = 2'b01, H_LEFT = 2'b10, H_RIGHT = 2'b11} head_t;

  state_t              state_q, state_d;
  head_t               heading_q, heading_d, req;
  logic                req_valid;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic [CELL_W-1:0]   lfsr_q, lfsr_d;
  logic [CELL_W-1:0]   pos_d, apple_d, score_d, next_cell;
  logic                step_d, ate_d, wall, tick_last;
  logic [2:0]          row, col, nrow, ncol;

  assign lfsr_d    = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
  assign tick_last = (cnt_q == TICK_LAST);

  // Heading: accept a single non-reversing press while playing; RIGHT on game start.
  always_comb begin
    heading_d = heading_q;
    req_valid = 1'b1;
    req       = heading_q;
    case ({dir_up, dir_down, dir_left, dir_right})
      4'b1000: req = H_UP;
      4'b0100: req = H_DOWN;
      4'b0010: req = H_LEFT;
      4'b0001: req = H_RIGHT;
      default: req_valid = 1'b0;
    endcase
    if (state_q == S_IDLE || state_q == S_DEAD) begin
      if (start) heading_d = H_RIGHT;
    end else if (req_valid && (2'(req) != (2'(heading_q) ^ 2'b01))) begin
      heading_d = req;
    end
  end

  // Candidate next head cell in 3-bit arithmetic, plus wall-crossing flag.
  always_comb begin
    row  = position[5:3];
    col  = position[2:0];
    nrow = row;
    ncol = col;
    wall = 1'b0;
    case (heading_d)
      H_UP:    begin nrow = row - 3'd1; wall = (row == 3'd0); end
      H_DOWN:  begin nrow = row + 3'd1; wall = (row == 3'd7); end
      H_LEFT:  begin ncol = col - 3'd1; wall = (col == 3'd0); end
      default: begin ncol = col + 3'd1; wall = (col == 3'd7); end
    endcase
`ifdef WRAP_AROUND_EN
    wall = 1'b0;
`endif
    next_cell = {nrow, ncol};
  end

  // Game FSM: next state, tick counter and next output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = position;
    apple_d = apple;
    score_d = score;
    step_d  = 1'b0;
    ate_d   = 1'b0;
    case (state_q)
      S_RUN: begin
        cnt_d = tick_last ? '0 : cnt_q + TICK_W'(1);
        if (tick_last) begin
          if (wall) begin
            state_d = S_DEAD;
          end else begin
            pos_d  = next_cell;
            step_d = 1'b1;
            if (next_cell == apple) begin
              ate_d   = 1'b1;
              score_d = (score == SCORE_MAX) ? score : score + CELL_W'(1);
              state_d = S_EAT;
            end
          end
        end
      end
      S_EAT: begin
        cnt_d = tick_last ? '0 : cnt_q + TICK_W'(1);
        if (lfsr_q != position) begin
          apple_d = lfsr_q;
          state_d = S_RUN;
        end
      end
      default: begin
        cnt_d = '0;
        if (start) begin
          pos_d   = INIT_POS;
          apple_d = INIT_APPLE;
          score_d = '0;
          state_d = S_RUN;
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      state_q   <= S_IDLE;
      heading_q <= H_RIGHT;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      position  <= INIT_POS;
      apple     <= INIT_APPLE;
      score     <= '0;
      step      <= 1'b0;
      ate       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      position  <= pos_d;
      apple     <= apple_d;
      score     <= score_d;
      step      <= step_d;
      ate       <= ate_d;
      game_over <= (state_d == S_DEAD);
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine with a cell/vector-level game model.
module tb_snake_engine;

  localparam int TC = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_EAT = 2, M_DEAD = 3;

  logic       clock = 1'b0;
  logic       restart_n = 1'b0;
  logic       start = 1'b0;
  logic       dir_up = 1'b0, dir_down = 1'b0, dir_left = 1'b0, dir_right = 1'b0;
  logic [5:0] position, apple, score;
  logic       step, ate, game_over;

  int checks = 0;
  int errors = 0;

  // Game model: head as (row, col), heading as a (dr, dc) unit vector.
  int m_state, m_row, m_col, m_dr, m_dc, m_apple, m_score, m_cnt, m_lfsr;
  bit m_step, m_ate, m_go;

  snake_engine #(.TICK_CYCLES(TC), .TICK_W(3)) dut (
    .clock(clock), .restart_n(restart_n), .start(start),
    .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
    .position(position), .apple(apple), .score(score),
    .step(step), .ate(ate), .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_state = M_IDLE; m_row = 3; m_col = 3; m_dr = 0; m_dc = 1;
    m_apple = 45; m_score = 0; m_cnt = 0; m_lfsr = 33;
    m_step = 0; m_ate = 0; m_go = 0;
  endtask

  task automatic model_edge();
    int nl, n, ndr, ndc, nr, nc;
    bit fire, off;
    nl = ((m_lfsr << 1) & 63) | (((m_lfsr >> 5) ^ (m_lfsr >> 4)) & 1);
    m_step = 0; m_ate = 0;
    if (m_state == M_IDLE || m_state == M_DEAD) begin
      m_cnt = 0;
      if (start) begin
        m_row = 3; m_col = 3; m_dr = 0; m_dc = 1;
        m_apple = 45; m_score = 0; m_state = M_RUN;
      end
    end else begin
      n = int'(dir_up) + int'(dir_down) + int'(dir_left) + int'(dir_right);
      if (n == 1) begin
        ndr = dir_up ? -1 : (dir_down ? 1 : 0);
        ndc = dir_left ? -1 : (dir_right ? 1 : 0);
        if (!(ndr == -m_dr && ndc == -m_dc)) begin m_dr = ndr; m_dc = ndc; end
      end
      fire = (m_cnt == TC - 1);
      m_cnt = fire ? 0 : m_cnt + 1;
      if (m_state == M_EAT) begin
        if (m_lfsr != m_row * 8 + m_col) begin m_apple = m_lfsr; m_state = M_RUN; end
      end else if (fire) begin
        nr = m_row + m_dr;
        nc = m_col + m_dc;
        off = (nr < 0) || (nr > 7) || (nc < 0) || (nc > 7);
`ifdef WRAP_AROUND_EN
        nr = (nr + 8) % 8;
        nc = (nc + 8) % 8;
        off = 0;
`endif
        if (off) begin
          m_state = M_DEAD;
        end else begin
          m_row = nr; m_col = nc; m_step = 1;
          if (nr * 8 + nc == m_apple) begin
            m_ate = 1;
            m_score = (m_score < 63) ? m_score + 1 : 63;
            m_state = M_EAT;
          end
        end
      end
    end
    m_lfsr = nl;
    m_go = (m_state == M_DEAD);
  endtask

  function automatic logic [20:0] exp_vec();
    return {6'(m_row * 8 + m_col), 6'(m_apple), 6'(m_score), m_step, m_ate, m_go};
  endfunction

  function automatic logic [20:0] got_vec();
    return {position, apple, score, step, ate, game_over};
  endfunction

  // One clock edge: model follows the inputs sampled at the edge; outputs settle by #1.
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    restart_n = 1'b0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    restart_n = 1'b1;
  endtask

  task automatic set_dirs(input logic u, input logic d, input logic l, input logic r);
    dir_up = u; dir_down = d; dir_left = l; dir_right = r;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (got_vec() !== {6'd27, 6'd45, 6'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_values got %h exp %h", got_vec(), {6'd27, 6'd45, 6'd0, 3'b000});
    end
    for (int i = 0; i < 8; i++) begin
      set_dirs(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      tick();
      checks++;
      if (got_vec() !== exp_vec() || step !== 1'b0) begin
        errors++; $display("FAIL idle_hold cyc %0d got %h exp %h", i, got_vec(), exp_vec());
      end
    end
    set_dirs(0, 0, 0, 0);
  endtask

  task automatic test_basic_step();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL basic_model k %0d got %h exp %h", k, got_vec(), exp_vec());
      end
      if (k == 4 || k == 8) begin
        checks++;
        if (position !== ((k == 4) ? 6'd28 : 6'd29) || step !== 1'b1 || score !== 6'd0) begin
          errors++; $display("FAIL basic_step k %0d got pos %0d step %b score %0d exp pos %0d step 1 score 0",
                             k, position, step, score, (k == 4) ? 28 : 29);
        end
      end
    end
  endtask

  task automatic test_reversal();
    set_dirs(0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL reversal_model k %0d got %h exp %h", k, got_vec(), exp_vec());
      end
    end
    checks++;
    if (position !== 6'd30) begin
      errors++; $display("FAIL reversal_reject got %0d exp 30", position);
    end
    set_dirs(1, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL multi_press_model k %0d got %h exp %h", k, got_vec(), exp_vec());
      end
    end
    checks++;
    if (position !== 6'd31) begin
      errors++; $display("FAIL multi_press got %0d exp 31", position);
    end
    set_dirs(0, 0, 0, 0);
  endtask

`ifndef WRAP_AROUND_EN
  task automatic test_wall();
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL wall_model k %0d got %h exp %h", k, got_vec(), exp_vec());
      end
      if (k == 4) begin
        checks++;
        if (game_over !== 1'b1 || position !== 6'd31 || step !== 1'b0) begin
          errors++; $display("FAIL wall_dead got go %b pos %0d step %b exp go 1 pos 31 step 0",
                             game_over, position, step);
        end
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (position !== 6'd27 || score !== 6'd0 || game_over !== 1'b0 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL wall_restart got %h exp %h", got_vec(), exp_vec());
    end
  endtask
`else
  task automatic test_wrap();
    logic [5:0] want [5] = '{6'd24, 6'd16, 6'd8, 6'd0, 6'd56};
    for (int s = 0; s < 5; s++) begin
      if (s == 1) set_dirs(1, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
        tick();
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++; $display("FAIL wrap_model s %0d k %0d got %h exp %h", s, k, got_vec(), exp_vec());
        end
      end
      checks++;
      if (position !== want[s] || game_over !== 1'b0) begin
        errors++; $display("FAIL wrap_step s %0d got pos %0d go %b exp pos %0d go 0", s, position, game_over, want[s]);
      end
    end
    set_dirs(0, 0, 0, 0);
  endtask
`endif

  task automatic test_apple();
    apply_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 9) set_dirs(0, 1, 0, 0);
      if (k == 17) set_dirs(0, 0, 0, 0);
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL apple_model k %0d got %h exp %h", k, got_vec(), exp_vec());
      end
      if (k == 12) begin
        checks++;
        if (position !== 6'd37) begin
          errors++; $display("FAIL turn_down got %0d exp 37", position);
        end
      end
      if (k == 16) begin
        checks++;
        if (position !== 6'd45 || ate !== 1'b1 || step !== 1'b1 || score !== 6'd1) begin
          errors++; $display("FAIL apple_eat got pos %0d ate %b step %b score %0d exp 45 1 1 1",
                             position, ate, step, score);
        end
      end
      if (k == 18) begin
        checks++;
        if (apple === 6'd45 || apple === 6'd0) begin
          errors++; $display("FAIL apple_move got %0d exp nonzero and not 45", apple);
        end
      end
      if (k == 24) begin
        checks++;
        if (position !== 6'd61 || score === 6'd0) begin
          errors++; $display("FAIL apple_resume got pos %0d score %0d exp pos 61 score >0", position, score);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    #2;
    restart_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (got_vec() !== {6'd27, 6'd45, 6'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset got %h exp %h", got_vec(), {6'd27, 6'd45, 6'd0, 3'b000});
    end
    @(posedge clock);
    #1;
    restart_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (got_vec() !== exp_vec() || step !== 1'b0 || position !== 6'd27) begin
        errors++; $display("FAIL post_reset_idle k %0d got %h exp %h", k, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      set_dirs(1'($urandom_range(2) == 0), 1'($urandom_range(2) == 0),
               1'($urandom_range(2) == 0), 1'($urandom_range(2) == 0));
      start = 1'($urandom_range(15) == 0);
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_model cyc %0d got %h exp %h", i, got_vec(), exp_vec());
      end
    end
    set_dirs(0, 0, 0, 0);
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_step();
    test_reversal();
`ifndef WRAP_AROUND_EN
    test_wall();
`else
    test_wrap();
`endif
    test_apple();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
# snake_engine

Game-logic stage that drives the 10×10 LED matrix renderer. It holds the snake head position, heading and apple location on the 8×8 interior playfield, and advances the head once per game tick. It detects apple capture and keeps the score. It produces the 6-bit `position` and `apple` cell codes that the matrix stage consumes.

## Interface
- `TICK_CYCLES`, 25_000_000: clock cycles per game step; must be ≥ 4.
- `TICK_W`, 25: tick counter width; must satisfy 2^TICK_W ≥ TICK_CYCLES.

- `clock` in 1: system clock, rising edge.
- `restart_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; starts or restarts a game from IDLE or DEAD.
- `dir_up`, `dir_down`, `dir_left`, `dir_right` in 1 each: synchronized button levels.
- `position` out 6: head cell, {row[2:0], col[2:0]}; row 0 is the top row, col 0 is the left column.
- `apple` out 6: apple cell, same encoding.
- `score` out 6: apples eaten; saturates at 63.
- `step` out 1: one-cycle pulse, coincident with each `position` update.
- `ate` out 1: one-cycle pulse, coincident with the `position` update that lands on the apple.
- `game_over` out 1: high while in DEAD.

## Operation
- States:
  - IDLE: after reset.
  - RUN: stepping.
  - EAT: relocating the apple.
  - DEAD: wall hit.
- Game init values, applied at reset and on start:
  - `position`=27 (row 3, col 3); `apple`=45 (row 5, col 5); `score`=0.
  - Heading=RIGHT; tick counter=0.
- IDLE/DEAD with `start`=1: apply game init values, go to RUN. `start` is ignored in RUN and EAT.
- Heading, RUN and EAT only:
  - Updated on any cycle where exactly one `dir_*` is high and it is not the opposite of the current heading.
  - Zero buttons, two or more buttons, or a reversal: heading unchanged.
- Tick counter:
  - Counts 0..TICK_CYCLES−1 in RUN and EAT, wraps to 0. It is held at 0 in IDLE and DEAD.
  - A step fires on the cycle the counter equals TICK_CYCLES−1.
- Step: next cell = head moved one cell in the current heading; row and col are computed in 3-bit arithmetic.
  - Edge crossing, no wrap: state→DEAD; `position` unchanged; no `step` pulse.
  - Next cell == `apple`: `position`←next; `score`+1 (saturating); `step`=`ate`=1; state→EAT.
  - Otherwise: `position`←next; `step`=1.
- Apple LFSR: 6-bit Fibonacci LFSR, taps x^6+x^5+1, seed 6'b100001.
  - Advances every cycle in every state except while reset is asserted.
  - Never reaches 0, so cell 0 is never an apple.
- EAT: each cycle, if the LFSR value ≠ `position`, then `apple`←LFSR and state→RUN; otherwise stay in EAT. Completes in ≤ 2 cycles.

## Timing
- All outputs are registered.
- Reset values: `position`=27, `apple`=45, `score`=0, `step`=0, `ate`=0, `game_over`=0, state=IDLE.
- Step latency: `position`, `step`, `ate` and `score` update on the edge after the counter reaches TICK_CYCLES−1.
- Start latency: `start` sampled high → RUN on the next edge. The first step lands TICK_CYCLES cycles later.
- Heading change: a press sampled on or before the step cycle affects that step.
- `game_over` rises on the edge after the offending step cycle. It falls on the edge after `start` is sampled.
- New `apple` is visible 1–2 cycles after the `ate` pulse.
- Because TICK_CYCLES ≥ 4, EAT always exits before the next step.
- Reset asserted mid-game: all outputs return to reset values immediately (asynchronously); state=IDLE.

## Configuration
- `WRAP_AROUND_EN` defined: edge crossing wraps modulo 8 on the crossed axis (col 7 →RIGHT→ col 0; row 0 →UP→ row 7). DEAD is unreachable, and `game_over` is constant 0.
- `WRAP_AROUND_EN` undefined: edge crossing → DEAD as described in Operation.

## Test plan
- Basic step: TICK_CYCLES=4, release reset, pulse `start` → `position` goes 27→28→29 at 4-cycle spacing, with one `step` pulse per move; `score`=0.
- Reversal reject: heading RIGHT, hold `dir_left` → next step goes to 29→30. Pressing `dir_up`+`dir_down` together → heading unchanged.
- Apple capture: RIGHT to 29, then `dir_down` → 37, 45 → `ate`=1 with `step`, `score`=1. `apple` becomes nonzero and ≠45 within 2 cycles; stepping resumes normally.
- Wall, macro undefined: heading RIGHT from 27 → 28, 29, 30, 31; next tick → `game_over`=1, `position` held at 31. `start` → `position`=27, `score`=0, `game_over`=0.
- Wall, `WRAP_AROUND_EN` defined: at 31 heading RIGHT → 24. `dir_up` at row 0 → row 7; `game_over` never asserts.
- Async reset: assert `restart_n`=0 mid-RUN between edges → outputs equal reset values before the next clock edge. After release, the block stays in IDLE with no `step` pulses until `start` is asserted.
